// File: rtl/rr_mux_arb_pkg.sv
// rr_mux_arb_pkg: shared arbiter state type and round-robin winner search
package rr_mux_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    localparam int MAX_N = 64;
    localparam int IDX_W = $clog2(MAX_N);

    // Scanning downward and overwriting leaves the first hit in ptr, ptr+1, ... order
    function automatic int rr_pick(input logic [MAX_N-1:0] valid, input int n, input int ptr);
        int w;
        int idx;
        w = ptr;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (i < n && valid[idx[IDX_W-1:0]]) w = idx;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_n_to_1_generic.sv
// mux_n_to_1_generic: N-to-1 data mux with zero output when disabled
module mux_n_to_1_generic #(
    parameter int N = 2,
    parameter int M = 8,
    parameter int SELECT_WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic [SELECT_WIDTH-1:0] select,
    input  logic                    enable,
    input  logic [M-1:0]            data [N-1:0],
    output logic [M-1:0]            out
);
    always_comb out = enable ? data[select] : '0;
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin burst arbiter steering N valid/ready streams onto one sink
module rr_mux_arbiter
    import rr_mux_arb_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 8,
    parameter int MAX_BURST = 16,
    parameter int SELECT_WIDTH = (N > 1) ? $clog2(N) : 1,
    parameter int CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N-1:0]            req_valid,
    output logic [N-1:0]            req_ready,
    input  logic [N-1:0]            req_last,
    input  logic [M-1:0]            req_data [N-1:0],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [M-1:0]            out_data,
    output logic                    out_last,
    output logic [N-1:0]            grant_onehot,
    output logic [SELECT_WIDTH-1:0] grant_index,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    beat_count
);
    arb_state_t state;
    logic [SELECT_WIDTH-1:0] rr_ptr;
    logic [SELECT_WIDTH-1:0] win;
    logic locked;
    logic force_rel;
    logic hs;

    assign locked    = state == LOCKED;
    assign busy      = locked;
    assign win       = SELECT_WIDTH'(rr_pick(MAX_N'(req_valid), N, int'(rr_ptr)));
    assign force_rel = beat_count == CNT_WIDTH'(MAX_BURST - 1);
    // Reset gates the handshake so no beat is taken while the burst is being aborted
    assign out_valid = !reset && locked && req_valid[grant_index];
    assign req_ready = (!reset && out_ready) ? grant_onehot : '0;
    assign out_last  = locked && (req_last[grant_index] || force_rel);
    assign hs        = out_valid && out_ready;

    mux_n_to_1_generic #(.N(N), .M(M), .SELECT_WIDTH(SELECT_WIDTH)) u_mux (
        .select(grant_index),
        .enable(locked),
        .data  (req_data),
        .out   (out_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_index  <= '0;
            grant_onehot <= '0;
            beat_count   <= '0;
        end else if (!locked) begin
            if (enable && |req_valid) begin
                state        <= LOCKED;
                grant_index  <= win;
                grant_onehot <= N'(1) << win;
            end
        end else if (hs) begin
            if (out_last) begin
                state        <= IDLE;
                rr_ptr       <= (grant_index == SELECT_WIDTH'(N - 1)) ? '0 : grant_index + SELECT_WIDTH'(1);
                beat_count   <= '0;
                grant_onehot <= '0;
            end else begin
                beat_count <= beat_count + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed plus random checks against a transaction-level arbiter model
module tb_rr_mux_arbiter;
    localparam int N = 4;
    localparam int M = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset, enable, out_ready, out_valid, out_last, busy;
    logic [N-1:0] req_valid, req_ready, req_last, grant_onehot;
    logic [M-1:0] req_data [N-1:0];
    logic [M-1:0] out_data;
    logic [1:0] grant_index;
    logic [2:0] beat_count;

    int n_vec = 0;
    int n_err = 0;
    bit m_busy;
    int m_g, m_cnt, m_ptr;
    int seq [N];
    int blen [N];

    always #5 clk = ~clk;

    rr_mux_arbiter #(.N(N), .M(M), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .grant_onehot(grant_onehot), .grant_index(grant_index), .busy(busy), .beat_count(beat_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Each requester presents a tagged sequence number, so a lost or repeated beat shows up as wrong data
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_data[i] = M'((i << 6) | (seq[i] & 63));
            req_last[i] = m_busy && m_g == i && m_cnt == blen[i] - 1;
        end
    endtask

    task automatic cycle();
        bit ev;
        drive();
        #1;
        ev = !reset && m_busy && req_valid[m_g];
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("req_ready", 32'(req_ready), (!reset && m_busy && out_ready) ? 32'(1 << m_g) : 32'd0);
        chk("grant_onehot", 32'(grant_onehot), m_busy ? 32'(1 << m_g) : 32'd0);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("beat_count", 32'(beat_count), 32'(m_cnt));
        if (!reset) begin
            chk("out_data", 32'(out_data), m_busy ? 32'(req_data[m_g]) : 32'd0);
            chk("out_last", 32'(out_last), 32'(m_busy && (req_last[m_g] || m_cnt == MB - 1)));
        end
        if (m_busy) chk("grant_index", 32'(grant_index), 32'(m_g));
        if (reset) begin
            m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
        end else if (!m_busy) begin
            if (enable && req_valid != 0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
                m_busy = 1;
            end
        end else if (ev && out_ready) begin
            seq[m_g]++;
            if (req_last[m_g] || m_cnt == MB - 1) begin
                m_busy = 0; m_ptr = (m_g + 1) % N; m_cnt = 0;
            end else m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1; enable = 0; req_valid = '0; out_ready = 0;
        m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) begin seq[i] = 0; blen[i] = 1; end
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_onehot", 32'(grant_onehot), 0);
        chk("rst_gidx", 32'(grant_index), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(beat_count), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_last", 32'(out_last), 0);
        reset = 0;
        // single requester, 3-beat burst
        enable = 1; out_ready = 1; blen[2] = 3; req_valid = 4'b0100;
        run(5);
        req_valid = '0;
        run(2);
        // everyone requesting, 1-beat bursts rotate 3,0,1,2,3...
        blen = '{1, 1, 1, 1};
        req_valid = 4'b1111;
        run(12);
        // requester 1 never ends its burst and is cut at MAX_BURST
        blen[1] = 0; req_valid = 4'b0110;
        run(14);
        // granted requester stalls for 3 cycles while downstream toggles ready
        req_valid = '0; run(2);
        blen[0] = 3;
        for (int c = 0; c < 14; c++) begin
            req_valid = (c >= 3 && c < 6) ? 4'b0000 : 4'b0001;
            out_ready = (c % 2 == 0) || c > 6;
            cycle();
        end
        out_ready = 1; req_valid = '0; run(2);
        // reset in the middle of a burst
        blen[3] = 0; req_valid = 4'b1000;
        for (int c = 0; c < 20 && !(m_busy && m_cnt == 2); c++) cycle();
        chk("t5_count2", 32'(beat_count), 2);
        reset = 1; cycle();
        reset = 0;
        chk("t5_gidx", 32'(grant_index), 0);
        req_valid = 4'b1111; blen = '{1, 1, 1, 1};
        run(4);
        // enable dropped mid-burst
        req_valid = '0; run(2);
        blen[0] = 3; req_valid = 4'b0001; run(2);
        enable = 0; req_valid = 4'b1111; run(8);
        enable = 1; run(4);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) blen[$urandom_range(0, N - 1)] = $urandom_range(0, 5);
            req_valid = N'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            enable = $urandom_range(0, 9) != 0;
            reset = $urandom_range(0, 99) == 0;
            cycle();
        end
        reset = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
